// File: rtl/train_sequencer.sv
// train_sequencer: drives a layer pipeline through NE training epochs of NS
// samples each, followed by one inference (test) pass over the same samples.
// Sample indices are issued over a valid/ready channel with at most MAXOUT
// samples in flight; each sample returns one completion token.
// Optional feature: define TRAIN_SEQUENCER_ACCURACY_EN to count hit flags
// returned during the test pass on oCorrect (otherwise oCorrect is 0).
module train_sequencer #(
  parameter int NS     = 16,
  parameter int NE     = 4,
  parameter int MAXOUT = 4
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iStart,
  output logic                 oMode,
  output logic                 oValid_BM_Index,
  input  logic                 iReady_BM_Index,
  output logic [$clog2(NS):0]  oData_BM_Index,
  input  logic                 iValid_AS_Done,
  output logic                 oReady_AS_Done,
  input  logic                 iData_AS_Done,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oErr,
  output logic [$clog2(NE):0]  oEpoch,
  output logic [$clog2(NS):0]  oCorrect
);

  localparam int IW = $clog2(NS) + 1;
  localparam int EW = $clog2(NE) + 1;
  localparam int OW = $clog2(MAXOUT) + 1;

  localparam logic [IW-1:0] NS_L   = IW'(NS);
  localparam logic [IW-1:0] LAST_L = IW'(NS - 1);
  localparam logic [EW-1:0] NE_L   = EW'(NE);
  localparam logic [OW-1:0] MAX_L  = OW'(MAXOUT);

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    DRAIN_T,
    TEST,
    DRAIN_E,
    DONE
  } state_t;

  state_t        state, stateNext;
  logic [IW-1:0] issued;
  logic [OW-1:0] outstanding;
  logic [EW-1:0] epochNext;
  logic          canIssue;
  logic          fire;
  logic          doneAccept;
  logic          spurious;
  logic          startRun;
  logic          clrIssue;
  logic          epochInc;

  assign canIssue       = (issued < NS_L) && (outstanding < MAX_L);
  assign fire           = oValid_BM_Index && iReady_BM_Index;
  assign doneAccept     = iValid_AS_Done && (outstanding != '0);
  assign spurious       = iValid_AS_Done && (outstanding == '0);
  assign epochNext      = oEpoch + EW'(1);
  assign oData_BM_Index = issued;
  assign oReady_AS_Done = 1'b1;

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state decode and state-derived outputs/controls.
  always_comb begin
    stateNext       = state;
    oValid_BM_Index = 1'b0;
    oMode           = 1'b0;
    oBusy           = 1'b0;
    oDone           = 1'b0;
    startRun        = 1'b0;
    clrIssue        = 1'b0;
    epochInc        = 1'b0;
    case (state)
      IDLE, DONE: begin
        oDone = (state == DONE);
        if (iStart) begin
          startRun  = 1'b1;
          stateNext = TRAIN;
        end
      end
      TRAIN: begin
        oMode           = 1'b1;
        oBusy           = 1'b1;
        oValid_BM_Index = canIssue;
        if (canIssue && iReady_BM_Index && (issued == LAST_L)) stateNext = DRAIN_T;
      end
      DRAIN_T: begin
        oMode = 1'b1;
        oBusy = 1'b1;
        // Mode may only flip once every training sample has come back.
        if (outstanding == '0) begin
          epochInc  = 1'b1;
          clrIssue  = 1'b1;
          stateNext = (epochNext == NE_L) ? TEST : TRAIN;
        end
      end
      TEST: begin
        oBusy           = 1'b1;
        oValid_BM_Index = canIssue;
        if (canIssue && iReady_BM_Index && (issued == LAST_L)) stateNext = DRAIN_E;
      end
      DRAIN_E: begin
        oBusy = 1'b1;
        if (outstanding == '0) stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Issue/outstanding counters, epoch counter and sticky error flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      issued      <= '0;
      outstanding <= '0;
      oEpoch      <= '0;
      oErr        <= 1'b0;
    end else if (startRun) begin
      issued      <= '0;
      outstanding <= '0;
      oEpoch      <= '0;
      oErr        <= 1'b0;
    end else begin
      if (clrIssue)  issued <= '0;
      else if (fire) issued <= issued + IW'(1);
      case ({fire, doneAccept})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (epochInc) oEpoch <= epochNext;
      if (spurious) oErr   <= 1'b1;
    end
  end

`ifdef TRAIN_SEQUENCER_ACCURACY_EN
  logic countHit;
  assign countHit = doneAccept && iData_AS_Done && ((state == TEST) || (state == DRAIN_E))
                    && (oCorrect < NS_L);

  // Saturating count of hits returned during the test pass.
  always_ff @(posedge iCLK) begin
    if (iRST || startRun) oCorrect <= '0;
    else if (countHit)    oCorrect <= oCorrect + IW'(1);
  end
`else
  logic unusedHitData;
  assign unusedHitData = iData_AS_Done;
  assign oCorrect      = '0;
`endif

endmodule

// File: tb/tb_train_sequencer.sv
// Self-checking bench for train_sequencer (NS=4, NE=2, MAXOUT=2).
// Expected issues are queued as mode*100+index and popped as the DUT fires.
module tb_train_sequencer;
  localparam int NS     = 4;
  localparam int NE     = 2;
  localparam int MAXOUT = 2;
  localparam int IW     = $clog2(NS) + 1;
  localparam int EW     = $clog2(NE) + 1;
`ifdef TRAIN_SEQUENCER_ACCURACY_EN
  localparam int EXP_CORRECT = 3;
`else
  localparam int EXP_CORRECT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          mode, valid, readyDone, busy, done, err;
  logic [IW-1:0] data, correct;
  logic [EW-1:0] epoch;
  logic          autoPulse = 1'b0;
  logic          autoHit = 1'b0;
  logic          manualDone = 1'b0;
  logic          doneValid, doneData;
  logic          autoEn = 1'b0;
  logic [3:0]    hitMask = 4'b1011;
  logic          prevMode = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fireCnt = 0;
  int modelOut = 0;
  int expQ[$];
  int dueQ[$];
  logic hitQ[$];

  assign doneValid = autoPulse | manualDone;
  assign doneData  = autoPulse & autoHit;

  always #5 clk = ~clk;

  train_sequencer #(.NS(NS), .NE(NE), .MAXOUT(MAXOUT)) dut (
    .iCLK            (clk),
    .iRST            (rst),
    .iStart          (start),
    .oMode           (mode),
    .oValid_BM_Index (valid),
    .iReady_BM_Index (ready),
    .oData_BM_Index  (data),
    .iValid_AS_Done  (doneValid),
    .oReady_AS_Done  (readyDone),
    .iData_AS_Done   (doneData),
    .oBusy           (busy),
    .oDone           (done),
    .oErr            (err),
    .oEpoch          (epoch),
    .oCorrect        (correct)
  );

  // Monitor: scoreboard for issues, in-flight model, mode-change rule.
  always @(negedge clk) begin
    int e;
    int oldOut;
    if (rst) begin
      dueQ.delete();
      hitQ.delete();
      modelOut = 0;
      prevMode = 1'b0;
    end else begin
      if (mode !== prevMode) begin
        tests++;
        if (modelOut != 0) begin
          fails++;
          $display("FAIL mode_change: outstanding=%0d when oMode became %0b, required 0", modelOut, mode);
        end
      end
      prevMode = mode;
      oldOut = modelOut;
      if (valid === 1'b1 && ready === 1'b1) begin
        fireCnt++;
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL issue_unexpected: got mode=%0b idx=%0d, required no issue", mode, data);
        end else begin
          e = expQ.pop_front();
          if ((int'(mode) * 100 + int'(data)) != e) begin
            fails++;
            $display("FAIL issue_order: got %0d, required %0d (mode*100+idx)", int'(mode) * 100 + int'(data), e);
          end
        end
        if (autoEn) begin
          dueQ.push_back(cyc + 3);
          hitQ.push_back(hitMask[data[1:0]]);
        end
        modelOut++;
      end
      if (doneValid && oldOut > 0) modelOut--;
    end
  end

  // Completion responder: returns a token three cycles after each issue.
  always @(posedge clk) begin
    cyc++;
    #1;
    autoPulse = 1'b0;
    if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
      autoPulse = 1'b1;
      autoHit   = hitQ.pop_front();
      void'(dueQ.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; start = 1'b0; ready = 1'b0; manualDone = 1'b0; autoEn = 1'b0;
    tick(2);
    rst = 1'b0;
    expQ.delete();
    fireCnt = 0;
    tick(1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] act[9];
    string nm[9];
    doReset();
    nm  = '{"oMode", "oValid", "oData", "oBusy", "oDone", "oErr", "oEpoch", "oCorrect", "oReady_inv"};
    act = '{16'(mode), 16'(valid), 16'(data), 16'(busy), 16'(done), 16'(err),
            16'(epoch), 16'(correct), 16'(!readyDone)};
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (act[i] !== 16'd0) begin
        fails++;
        $display("FAIL reset_%s: got %0h, required 0", nm[i], act[i]);
      end
    end
  endtask

  task automatic test_full_run();
    int n;
    doReset();
    hitMask = 4'b1011;
    ready = 1'b1;
    autoEn = 1'b1;
    for (int ep = 0; ep < NE; ep++)
      for (int i = 0; i < NS; i++) expQ.push_back(100 + i);
    for (int i = 0; i < NS; i++) expQ.push_back(i);
    pulseStart();
    tests++;
    if (valid !== 1'b1 || data !== '0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_latency: got valid=%0b data=%0d busy=%0b, required 1 0 1", valid, data, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL run_done: got oDone=%0b, required 1", done); end
    tests++;
    if (expQ.size() != 0) begin fails++; $display("FAIL run_issues: %0d issues missing, required 0", expQ.size()); end
    tests++;
    if (epoch !== EW'(NE)) begin fails++; $display("FAIL run_epoch: got %0d, required %0d", epoch, NE); end
    tests++;
    if (busy !== 1'b0 || mode !== 1'b0) begin
      fails++; $display("FAIL run_idle_out: got busy=%0b mode=%0b, required 0 0", busy, mode);
    end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL run_err: got %0b, required 0", err); end
    tests++;
    if (correct !== IW'(EXP_CORRECT)) begin
      fails++; $display("FAIL run_correct: got %0d, required %0d", correct, EXP_CORRECT);
    end
    autoEn = 1'b0;
    ready = 1'b0;
    pulseStart();
    tests++;
    if (epoch !== '0 || correct !== '0 || done !== 1'b0 || busy !== 1'b1 || valid !== 1'b1) begin
      fails++;
      $display("FAIL restart: got epoch=%0d correct=%0d done=%0b busy=%0b valid=%0b, required 0 0 0 1 1",
               epoch, correct, done, busy, valid);
    end
  endtask

  task automatic test_maxout();
    doReset();
    ready = 1'b1;
    expQ.push_back(100);
    expQ.push_back(101);
    pulseStart();
    tick(10);
    tests++;
    if (fireCnt != MAXOUT) begin fails++; $display("FAIL maxout_issues: got %0d, required %0d", fireCnt, MAXOUT); end
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL maxout_valid: got %0b, required 0", valid); end
    expQ.push_back(102);
    manualDone = 1'b1;
    tick(1);
    manualDone = 1'b0;
    tests++;
    if (valid !== 1'b1 || data !== IW'(2)) begin
      fails++; $display("FAIL maxout_resume: got valid=%0b data=%0d, required 1 2", valid, data);
    end
    tick(2);
    tests++;
    if (fireCnt != 3 || valid !== 1'b0) begin
      fails++; $display("FAIL maxout_refill: got issues=%0d valid=%0b, required 3 0", fireCnt, valid);
    end
  endtask

  task automatic test_backpressure();
    doReset();
    pulseStart();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (valid !== 1'b1 || data !== '0 || fireCnt != 0) begin
        fails++;
        $display("FAIL stall_hold: got valid=%0b data=%0d issues=%0d, required 1 0 0", valid, data, fireCnt);
      end
      tick(1);
    end
    expQ.push_back(100);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tests++;
    if (fireCnt != 1 || data !== IW'(1)) begin
      fails++; $display("FAIL stall_release: got issues=%0d data=%0d, required 1 1", fireCnt, data);
    end
  endtask

  task automatic test_same_cycle();
    doReset();
    pulseStart();
    expQ.push_back(100);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    expQ.push_back(101);
    ready = 1'b1;
    manualDone = 1'b1;
    tick(1);
    ready = 1'b0;
    manualDone = 1'b0;
    tests++;
    if (valid !== 1'b1 || data !== IW'(2)) begin
      fails++; $display("FAIL same_cycle_out1: got valid=%0b data=%0d, required 1 2", valid, data);
    end
    expQ.push_back(102);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tests++;
    if (valid !== 1'b0 || fireCnt != 3) begin
      fails++; $display("FAIL same_cycle_out2: got valid=%0b issues=%0d, required 0 3", valid, fireCnt);
    end
  endtask

  task automatic test_spurious();
    doReset();
    manualDone = 1'b1;
    tick(1);
    manualDone = 1'b0;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL spurious_set: got %0b, required 1", err); end
    tick(3);
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL spurious_sticky: got %0b, required 1", err); end
    pulseStart();
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL spurious_start_clr: got err=%0b busy=%0b, required 0 1", err, busy);
    end
    doReset();
    manualDone = 1'b1;
    tick(1);
    manualDone = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL spurious_rst_clr: got %0b, required 0", err); end
  endtask

  task automatic test_reset_midrun();
    int n;
    logic [15:0] act[9];
    string nm[9];
    doReset();
    ready = 1'b1;
    autoEn = 1'b1;
    for (int ep = 0; ep < NE; ep++)
      for (int i = 0; i < NS; i++) expQ.push_back(100 + i);
    pulseStart();
    n = 0;
    while (!(epoch === EW'(1) && mode === 1'b1 && valid === 1'b1) && n < 200) begin
      tick(1);
      n++;
    end
    tests++;
    if (epoch !== EW'(1) || mode !== 1'b1) begin
      fails++; $display("FAIL midrun_reach: got epoch=%0d mode=%0b, required 1 1", epoch, mode);
    end
    autoEn = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expQ.delete();
    nm  = '{"oMode", "oValid", "oData", "oBusy", "oDone", "oErr", "oEpoch", "oCorrect", "oReady_inv"};
    act = '{16'(mode), 16'(valid), 16'(data), 16'(busy), 16'(done), 16'(err),
            16'(epoch), 16'(correct), 16'(!readyDone)};
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (act[i] !== 16'd0) begin
        fails++;
        $display("FAIL midrun_%s: got %0h, required 0", nm[i], act[i]);
      end
    end
    tick(5);
    tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrun_quiet: got err=%0b busy=%0b, required 0 0", err, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_maxout();
    test_backpressure();
    test_same_cycle();
    test_spurious();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/train_sequencer.md
TRAIN_SEQUENCER -- requirements
Module: train_sequencer

Interface
REQ-001 SHALL have parameter NS, default 16: samples per epoch (>=1).
REQ-002 SHALL have parameter NE, default 4: training epochs before the test pass (>=1).
REQ-003 SHALL have parameter MAXOUT, default 4: maximum samples in flight in the layer pipeline (>=1).
REQ-004 SHALL have ports: iCLK in 1, single clock, all logic on rising edge; iRST in 1, synchronous active-high reset.
REQ-005 SHALL have ports: iStart in 1, one-cycle start pulse, honoured only in IDLE or DONE.
REQ-006 SHALL have ports: oMode out 1, layer mode (1 = train, 0 = inference), driven to all layer iMode inputs.
REQ-007 SHALL have ports: oValid_BM_Index out 1, iReady_BM_Index in 1, oData_BM_Index out $clog2(NS)+1, sample index issued to the dataset/teacher source.
REQ-008 SHALL have ports: iValid_AS_Done in 1, oReady_AS_Done out 1, iData_AS_Done in 1; completion token per sample, data = hit flag.
REQ-009 SHALL have ports: oBusy out 1, oDone out 1, oErr out 1, oEpoch out $clog2(NE)+1, oCorrect out $clog2(NS)+1.

Function
REQ-010 SHALL use FSM states IDLE, TRAIN, DRAIN_T, TEST, DRAIN_E, DONE.
REQ-011 SHALL go IDLE/DONE -> TRAIN on iStart, clearing issue count, outstanding count, oEpoch, oCorrect and oErr.
REQ-012 SHALL assert oValid_BM_Index in TRAIN/TEST only while issued < NS and outstanding < MAXOUT.
REQ-013 SHALL hold oData_BM_Index stable while oValid_BM_Index=1 and iReady_BM_Index=0; an issue fires only on valid&&ready.
REQ-014 SHALL issue indices 0..NS-1 in order in every epoch and test pass; each fire increments the issue count.
REQ-015 SHALL tie oReady_AS_Done to 1; each iValid_AS_Done decrements outstanding.
REQ-016 SHALL leave outstanding unchanged when an issue and a completion occur in the same cycle.
REQ-017 SHALL, on a completion while outstanding==0, ignore the completion and set sticky oErr.
REQ-018 SHALL go TRAIN -> DRAIN_T in the cycle after issue NS-1 fires; TEST -> DRAIN_E likewise.
REQ-019 SHALL, in DRAIN_T with outstanding==0, increment oEpoch, then go to TEST if the new oEpoch==NE, else to TRAIN with the issue count cleared.
REQ-020 SHALL, in DRAIN_E with outstanding==0, go to DONE.
REQ-021 SHALL drive oMode=1 in TRAIN/DRAIN_T and oMode=0 otherwise; oMode SHALL change only while outstanding==0.
REQ-022 SHALL drive oBusy=1 in TRAIN..DRAIN_E; oDone=1 only in DONE.
REQ-023 SHALL have latency of one cycle from iStart to the first oValid_BM_Index.

Reset
REQ-024 SHALL on iRST enter IDLE with oMode=0, oValid_BM_Index=0, oData_BM_Index=0, oBusy=0, oDone=0, oErr=0, oEpoch=0, oCorrect=0, and all counts zero.
REQ-025 SHALL abort any operation on iRST asserted mid-epoch; tokens already in flight are not tracked.

Configuration
REQ-026 SHALL, with macro TRAIN_SEQUENCER_ACCURACY_EN defined, increment oCorrect on each completion in TEST/DRAIN_E with iData_AS_Done=1, saturating at NS.
REQ-027 SHALL, without TRAIN_SEQUENCER_ACCURACY_EN, tie oCorrect to 0 and ignore iData_AS_Done.

Verification
REQ-028 SHALL cover: NS=4, NE=2, ready always 1, completions 3 cycles after issue -> indices 0..3 issued twice with oMode=1, then 0..3 with oMode=0, then oDone=1, oEpoch=2.
REQ-029 SHALL cover: MAXOUT=2, no completions -> exactly 2 issues, then oValid_BM_Index held 0 until a completion.
REQ-030 SHALL cover: iReady_BM_Index low 5 cycles during valid -> oData_BM_Index stable, issue count unchanged.
REQ-031 SHALL cover: issue and completion in the same cycle at outstanding=1 -> outstanding stays 1.
REQ-032 SHALL cover: spurious completion in IDLE -> oErr=1 until next iStart or iRST.
REQ-033 SHALL cover: iRST asserted in TRAIN epoch 1 -> next cycle IDLE, all outputs at reset values; with ACCURACY_EN, 3 hits in a test pass of NS=4 -> oCorrect=3.
